// File: rtl/noc_port_vc_allocator_if.sv
// ---------------------------------------------------------------------------
// noc_port_vc_allocator_if
// Control handshake between the input-VC route selectors of a router and the
// VC allocator that owns one output port.
//   request         : requester r has a valid flit for this output port
//   free            : requester r flit accepted downstream (ready)
//   start_of_packet : requester r presents a header flit
//   end_of_packet   : requester r tail flit transferred this cycle
//   grant           : one-hot (or zero) owner of the output link
//   busy            : output link locked to a packet
//   stall_err       : sticky stall indication
// master = route-selector side, slave = allocator side.
// ---------------------------------------------------------------------------
interface noc_port_vc_allocator_if #(
    parameter int NUM_REQ = 20
);
    logic [NUM_REQ-1:0] request;
    logic [NUM_REQ-1:0] free;
    logic [NUM_REQ-1:0] start_of_packet;
    logic [NUM_REQ-1:0] end_of_packet;
    logic [NUM_REQ-1:0] grant;
    logic               busy;
    logic               stall_err;

    modport master (
        output request, free, start_of_packet, end_of_packet,
        input  grant, busy, stall_err
    );

    modport slave (
        input  request, free, start_of_packet, end_of_packet,
        output grant, busy, stall_err
    );
endinterface

// File: rtl/noc_port_vc_allocator.sv
// ---------------------------------------------------------------------------
// noc_port_vc_allocator
// Per-output-port wormhole allocator. Grants the output link to one header
// requester at a time (round-robin), holds the grant until that requester's
// tail flit, and flags a sticky error if the owner stalls too long.
// Ports:
//   noc_clk   : clock
//   noc_rst_n : asynchronous active-low reset
//   ctrl_if   : slave side of the allocator handshake (request/free/
//               start_of_packet/end_of_packet in, grant/busy/stall_err out)
// ---------------------------------------------------------------------------
module noc_port_vc_allocator #(
    parameter int NUM_REQ     = 20,
    parameter int STALL_LIMIT = 255
) (
    input  logic                     noc_clk,
    input  logic                     noc_rst_n,
    noc_port_vc_allocator_if.slave   ctrl_if
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(STALL_LIMIT + 1);
    localparam logic [NUM_REQ-1:0] ONE_LSB   = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(STALL_LIMIT);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Round-robin search starting at ptr; returns {found, index}. The loop
    // runs from the far end back to ptr so the last hit is the first in order.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx_v;
        int               idx;
        res = {(IDX_W+1){1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            idx_v = idx[IDX_W-1:0];
            if (elig[idx_v]) begin
                res = {1'b1, idx_v};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Index following i, wrapping at NUM_REQ.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_REQ - 1)) begin
            return {IDX_W{1'b0}};
        end else begin
            return i + IDX_W'(1);
        end
    endfunction

    state_t             state_q,  state_d;
    logic [NUM_REQ-1:0] grant_q,  grant_d;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic [IDX_W-1:0]   ptr_q,    ptr_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               err_q,    err_d;

    logic [NUM_REQ-1:0] elig_s;
    logic [IDX_W:0]     pick_s;
    logic               pick_found_s;
    logic [IDX_W-1:0]   pick_idx_s;

    // Eligible headers; the current owner is masked so a release can hand over
    // to someone else in the same cycle (grant_q is zero while idle).
    assign elig_s       = ctrl_if.request & ctrl_if.start_of_packet & ~grant_q;
    assign pick_s       = rr_pick(elig_s, ptr_q);
    assign pick_found_s = pick_s[IDX_W];
    assign pick_idx_s   = pick_s[IDX_W-1:0];

    // Next-state, grant, pointer and stall-counter logic.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        winner_d = winner_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (pick_found_s) begin
                    grant_d  = ONE_LSB << pick_idx_s;
                    winner_d = pick_idx_s;
                    ptr_d    = next_idx(pick_idx_s);
                    state_d  = ST_LOCKED;
                end else begin
                    grant_d  = {NUM_REQ{1'b0}};
                end
            end
            ST_LOCKED: begin
                if (ctrl_if.end_of_packet[winner_q]) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (pick_found_s) begin
                        grant_d  = ONE_LSB << pick_idx_s;
                        winner_d = pick_idx_s;
                        ptr_d    = next_idx(pick_idx_s);
                    end else begin
                        grant_d  = {NUM_REQ{1'b0}};
                        state_d  = ST_IDLE;
                    end
                end else if (ctrl_if.free[winner_q]) begin
                    cnt_d = {CNT_W{1'b0}};
                end else if (ctrl_if.request[winner_q] && (cnt_q != CNT_LIMIT)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = {NUM_REQ{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        // Counter only reaches the limit on a stalled locked cycle.
        if (cnt_d == CNT_LIMIT) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State and output registers; reset drops the grant immediately.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= {NUM_REQ{1'b0}};
            winner_q <= {IDX_W{1'b0}};
            ptr_q    <= {IDX_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            winner_q <= winner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign ctrl_if.grant     = grant_q;
    assign ctrl_if.busy      = (state_q == ST_LOCKED);
    assign ctrl_if.stall_err = err_q;

endmodule
